// File: rtl/axi_lite_sram_slave.sv
// rtl/axi_lite_sram_slave.sv - AXI4-Lite responder modelling on-chip data SRAM
//
// Purpose:
//   Word-organised SRAM behind an AXI4-Lite port. Read and write channels run
//   independently, each with one outstanding transaction and a programmable
//   response latency. Writes honour wstrb byte lanes as given.
//   Out-of-window accesses return DECERR. Misaligned or oversize accesses
//   return SLVERR. Erroring writes never touch memory.
//
// Ports:
//   clock, reset                 clock, synchronous active-high reset
//   arvalid/araddr/arsize/arready  read address channel
//   rvalid/rdata/rresp/rready      read data channel (rdata is the full aligned word)
//   awvalid/awaddr/awsize/awready  write address channel
//   wvalid/wdata/wstrb/wready      write data channel
//   bvalid/bresp/bready            write response channel
//
// Optional feature macro: SRAM_RAND_DELAY_EN
//   When defined, an 8-bit LFSR adds 0..7 random cycles to every latency load.

module axi_lite_sram_slave #(
   parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          RD_LAT      = 1,
   parameter int          WR_LAT      = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        arvalid,
   input  logic [31:0] araddr,
   input  logic [2:0]  arsize,
   output logic        arready,
   output logic        rvalid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   input  logic        rready,
   input  logic        awvalid,
   input  logic [31:0] awaddr,
   input  logic [2:0]  awsize,
   output logic        awready,
   input  logic        wvalid,
   input  logic [31:0] wdata,
   input  logic [3:0]  wstrb,
   output logic        wready,
   output logic        bvalid,
   output logic [1:0]  bresp,
   input  logic        bready
);

   localparam int          IDXW      = $clog2(DEPTH_WORDS);
   localparam logic [31:0] WIN_BYTES = 32'(DEPTH_WORDS * 4);
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;
   localparam logic [1:0]  RESP_DECERR = 2'b11;

   // Wrapping 32-bit subtraction makes addresses below the base fall out of range too.
   function automatic logic [1:0] decode_resp(input logic [31:0] addr, input logic [2:0] size);
      logic misaligned;
      misaligned = (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00) || (size > 3'd2);
      if ((addr - ADDR_BASE) >= WIN_BYTES) return RESP_DECERR;
      else if (misaligned)                 return RESP_SLVERR;
      else                                 return RESP_OKAY;
   endfunction

   logic [31:0] mem [DEPTH_WORDS];

   // Counters are 5 bits so LAT (max 15) plus the random extra (max 7) fits.
   logic [4:0] rd_load, wr_load;

`ifdef SRAM_RAND_DELAY_EN
   logic [7:0] lfsr;

   // Fibonacci LFSR, taps 8,6,5,4.
   always_ff @(posedge clock) begin
      if (reset) lfsr <= 8'hA5;
      else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
   end

   assign rd_load = 5'(RD_LAT) + {2'b00, lfsr[2:0]};
   assign wr_load = 5'(WR_LAT) + {2'b00, lfsr[2:0]};
`else
   assign rd_load = 5'(RD_LAT);
   assign wr_load = 5'(WR_LAT);
`endif

   // ---------------------------------------------------------------- read
   typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} r_state_t;
   r_state_t        r_state, r_state_nxt;
   logic [4:0]      r_cnt;
   logic [IDXW-1:0] r_idx;
   logic [1:0]      r_code;

   always_ff @(posedge clock) begin
      if (reset) r_state <= R_IDLE;
      else       r_state <= r_state_nxt;
   end

   always_comb begin
      r_state_nxt = r_state;
      arready     = 1'b0;
      case (r_state)
         R_IDLE: begin
            arready = !reset;
            if (arvalid) r_state_nxt = R_WAIT;
         end
         R_WAIT:  if (r_cnt == 5'd0) r_state_nxt = R_RESP;
         R_RESP:  if (rready)        r_state_nxt = R_IDLE;
         default: r_state_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_cnt  <= 5'd0;
         r_idx  <= '0;
         r_code <= RESP_OKAY;
         rvalid <= 1'b0;
         rdata  <= 32'd0;
         rresp  <= RESP_OKAY;
      end else begin
         case (r_state)
            R_IDLE: if (arvalid) begin
               r_idx  <= IDXW'((araddr - ADDR_BASE) >> 2);
               r_code <= decode_resp(araddr, arsize);
               r_cnt  <= rd_load;
            end
            R_WAIT: if (r_cnt == 5'd0) begin
               // Sampled before any same-edge write commit lands, so a colliding read sees old data.
               rvalid <= 1'b1;
               rresp  <= r_code;
               rdata  <= (r_code == RESP_OKAY) ? mem[r_idx] : 32'd0;
            end else begin
               r_cnt <= r_cnt - 5'd1;
            end
            R_RESP: if (rready) rvalid <= 1'b0;
            default: ;
         endcase
      end
   end

   // --------------------------------------------------------------- write
   typedef enum logic [1:0] {W_IDLE, W_WAIT, W_RESP} w_state_t;
   w_state_t        w_state, w_state_nxt;
   logic [4:0]      w_cnt;
   logic [IDXW-1:0] w_idx;
   logic [1:0]      w_code;
   logic [31:0]     w_data;
   logic [3:0]      w_strb;
   logic            aw_held, w_held;
   logic            aw_fire, w_fire, both_held;

   assign aw_fire   = awvalid && awready;
   assign w_fire    = wvalid && wready;
   assign both_held = (aw_held || aw_fire) && (w_held || w_fire);

   always_ff @(posedge clock) begin
      if (reset) w_state <= W_IDLE;
      else       w_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = w_state;
      awready     = 1'b0;
      wready      = 1'b0;
      case (w_state)
         W_IDLE: begin
            awready = !reset && !aw_held;
            wready  = !reset && !w_held;
            if (both_held) w_state_nxt = W_WAIT;
         end
         W_WAIT:  if (w_cnt == 5'd0) w_state_nxt = W_RESP;
         W_RESP:  if (bready)        w_state_nxt = W_IDLE;
         default: w_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_cnt   <= 5'd0;
         w_idx   <= '0;
         w_code  <= RESP_OKAY;
         w_data  <= 32'd0;
         w_strb  <= 4'd0;
         aw_held <= 1'b0;
         w_held  <= 1'b0;
         bvalid  <= 1'b0;
         bresp   <= RESP_OKAY;
      end else begin
         case (w_state)
            W_IDLE: begin
               if (aw_fire) begin
                  aw_held <= 1'b1;
                  w_idx   <= IDXW'((awaddr - ADDR_BASE) >> 2);
                  w_code  <= decode_resp(awaddr, awsize);
               end
               if (w_fire) begin
                  w_held <= 1'b1;
                  w_data <= wdata;
                  w_strb <= wstrb;
               end
               // Later assignments win: the held flags are consumed as soon as both halves exist.
               if (both_held) begin
                  w_cnt   <= wr_load;
                  aw_held <= 1'b0;
                  w_held  <= 1'b0;
               end
            end
            W_WAIT: if (w_cnt == 5'd0) begin
               bvalid <= 1'b1;
               bresp  <= w_code;
            end else begin
               w_cnt <= w_cnt - 5'd1;
            end
            W_RESP: if (bready) bvalid <= 1'b0;
            default: ;
         endcase
      end
   end

   // Memory contents have no reset; a reset on the commit edge suppresses the write.
   always_ff @(posedge clock) begin
      if (!reset && w_state == W_WAIT && w_cnt == 5'd0 && w_code == RESP_OKAY) begin
         for (int b = 0; b < 4; b++) begin
            if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
         end
      end
   end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// tb/tb_axi_lite_sram_slave.sv - self-checking bench for axi_lite_sram_slave

module tb_axi_lite_sram_slave;

   localparam logic [31:0] BASE   = 32'h8000_0000;
   localparam int          RD_LAT = 1;
   localparam int          WR_LAT = 1;

   logic        clock, reset;
   logic        arvalid, arready, rvalid, rready;
   logic [31:0] araddr, rdata;
   logic [2:0]  arsize;
   logic [1:0]  rresp;
   logic        awvalid, awready, wvalid, wready, bvalid, bready;
   logic [31:0] awaddr, wdata;
   logic [2:0]  awsize;
   logic [3:0]  wstrb;
   logic [1:0]  bresp;

   axi_lite_sram_slave #(
      .ADDR_BASE(BASE), .DEPTH_WORDS(1024), .RD_LAT(RD_LAT), .WR_LAT(WR_LAT)
   ) dut (
      .clock(clock), .reset(reset),
      .arvalid(arvalid), .araddr(araddr), .arsize(arsize), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rready(rready),
      .awvalid(awvalid), .awaddr(awaddr), .awsize(awsize), .awready(awready),
      .wvalid(wvalid), .wdata(wdata), .wstrb(wstrb), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] model [1024];
   logic [33:0] rq [$];
   logic [1:0]  bq [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] exp_resp(input logic [31:0] addr, input logic [2:0] size);
      logic [31:0] off;
      off = addr - BASE;
      if (off >= 32'd4096) return 2'b11;
      if (size > 3'd2 || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00)) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int widx(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE;
      return int'(off[11:2]);
   endfunction

   // mode 0: AW and W together, 1: AW one cycle before W, 2: W one cycle before AW
   task automatic axi_write(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data,
                            input logic [3:0] strb, input int mode, input int hold);
      logic       aw_done, w_done, aw_hs, w_hs;
      logic [1:0] er, b0;
      int         cyc, n;
      er = exp_resp(addr, size);
      bq.push_back(er);
      @(negedge clock);
      awaddr = addr; awsize = size; wdata = data; wstrb = strb;
      awvalid = (mode != 2); wvalid = (mode != 1);
      aw_done = 1'b0; w_done = 1'b0; cyc = 0;
      while (!(aw_done && w_done) && cyc < 20) begin
         aw_hs = awvalid && awready;
         w_hs  = wvalid && wready;
         @(negedge clock);
         cyc++;
         if (aw_hs) begin awvalid = 1'b0; aw_done = 1'b1; end
         if (w_hs)  begin wvalid  = 1'b0; w_done  = 1'b1; end
         if (cyc == 1 && mode == 1 && !w_done)  wvalid  = 1'b1;
         if (cyc == 1 && mode == 2 && !aw_done) awvalid = 1'b1;
      end
      awvalid = 1'b0; wvalid = 1'b0;
      check("wr_handshakes", {30'd0, aw_done, w_done}, 32'd3);
      n = 0;
      while (!bvalid && n < 50) begin @(negedge clock); n++; end
      check("bvalid_seen", bvalid, 1);
`ifndef SRAM_RAND_DELAY_EN
      check("b_latency", n, WR_LAT + 1);
`endif
      b0 = bresp;
      for (int i = 0; i < hold; i++) begin
         check("b_hold_valid", bvalid, 1);
         check("b_hold_resp", bresp, b0);
         check("aw_w_ready_busy", {awready, wready}, 0);
         @(negedge clock);
      end
      bready = 1'b1;
      check("bresp", bresp, bq.pop_front());
      @(negedge clock);
      bready = 1'b0;
      check("bvalid_drop", bvalid, 0);
      if (er == 2'b00)
         for (int b = 0; b < 4; b++)
            if (strb[b]) model[widx(addr)][8*b +: 8] = data[8*b +: 8];
   endtask

   task automatic axi_read(input logic [31:0] addr, input logic [2:0] size);
      logic [1:0]  er;
      logic [33:0] e;
      logic        done, hs;
      int          cyc, n;
      er = exp_resp(addr, size);
      rq.push_back({er, (er == 2'b00) ? model[widx(addr)] : 32'd0});
      @(negedge clock);
      araddr = addr; arsize = size; arvalid = 1'b1; rready = 1'b1;
      done = 1'b0; cyc = 0;
      while (!done && cyc < 20) begin
         hs = arvalid && arready;
         @(negedge clock);
         cyc++;
         if (hs) begin arvalid = 1'b0; done = 1'b1; end
      end
      arvalid = 1'b0;
      check("ar_handshake", done, 1);
      n = 0;
      while (!rvalid && n < 50) begin @(negedge clock); n++; end
      check("rvalid_seen", rvalid, 1);
`ifndef SRAM_RAND_DELAY_EN
      // counting the handshake edge itself as cycle 1, rvalid shows on cycle RD_LAT+2
      check("r_latency", n + 1, RD_LAT + 2);
`endif
      check("arready_busy", arready, 0);
      e = rq.pop_front();
      check("rdata", rdata, e[31:0]);
      check("rresp", rresp, e[33:32]);
      @(negedge clock);
      rready = 1'b0;
      check("rvalid_drop", rvalid, 0);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      arvalid = 0; araddr = 0; arsize = 0; rready = 0;
      awvalid = 0; awaddr = 0; awsize = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      check("rst_arready", arready, 0);
      check("rst_awready", awready, 0);
      check("rst_wready", wready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bvalid", bvalid, 0);
      check("rst_rdata", rdata, 0);
      check("rst_rresp", rresp, 0);
      check("rst_bresp", bresp, 0);
      reset = 1'b0;
      @(negedge clock);
      check("idle_ready", {arready, awready, wready}, 3'b111);

      // preload and halfword-addressed read of a full word
      axi_write(32'h8000_0010, 3'd2, 32'hDEAD_BEEF, 4'hF, 0, 0);
      axi_read (32'h8000_0012, 3'd1);

      // strobed byte write with AW leading W by one cycle
      axi_write(32'h8000_0004, 3'd2, 32'h1122_3344, 4'hF, 0, 0);
      axi_write(32'h8000_0004, 3'd2, 32'h0000_AB00, 4'b0010, 1, 0);
      axi_read (32'h8000_0004, 3'd2);

      // same-cycle AW/W with B back-pressure; W leading AW on the last word
      axi_write(32'h8000_0008, 3'd2, 32'h5566_7788, 4'hF, 0, 5);
      axi_write(32'h8000_0FFC, 3'd2, 32'h0F0F_1234, 4'hF, 2, 1);
      axi_read (32'h8000_0008, 3'd2);
      axi_read (32'h8000_0FFC, 3'd2);

      // error decoding; erroring writes must leave memory alone
      axi_write(32'h8000_0000, 3'd2, 32'hCAFE_F00D, 4'hF, 0, 0);
      axi_read (32'h9000_0000, 3'd2);
      axi_read (32'h8000_1000, 3'd2);
      axi_read (32'h7FFF_FFFC, 3'd2);
      axi_read (32'h8000_0001, 3'd1);
      axi_read (32'h8000_0004, 3'd3);
      axi_read (32'h8000_0003, 3'd0);
      axi_write(32'h8000_0002, 3'd2, 32'hFFFF_FFFF, 4'hF, 0, 0);
      axi_write(32'h8000_1000, 3'd2, 32'hEEEE_EEEE, 4'hF, 1, 0);
      axi_read (32'h8000_0000, 3'd2);

`ifndef SRAM_RAND_DELAY_EN
      // read capture and write commit on the same word in the same cycle
      rq.push_back({2'b00, model[4]});
      bq.push_back(2'b00);
      @(negedge clock);
      araddr = 32'h8000_0010; arsize = 3'd2; arvalid = 1'b1; rready = 1'b1;
      awaddr = 32'h8000_0010; awsize = 3'd2; awvalid = 1'b1;
      wdata = 32'h0BAD_CAFE; wstrb = 4'hF; wvalid = 1'b1; bready = 1'b1;
      check("coll_ready", {arready, awready, wready}, 3'b111);
      @(negedge clock);
      arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      repeat (RD_LAT + 1) @(negedge clock);
      check("coll_rvalid", rvalid, 1);
      check("coll_bvalid", bvalid, 1);
      begin
         logic [33:0] e;
         e = rq.pop_front();
         check("coll_rdata_old", rdata, e[31:0]);
         check("coll_rresp", rresp, e[33:32]);
      end
      check("coll_bresp", bresp, bq.pop_front());
      @(negedge clock);
      rready = 1'b0; bready = 1'b0;
      check("coll_done", {rvalid, bvalid}, 0);
      model[4] = 32'h0BAD_CAFE;
      axi_read(32'h8000_0010, 3'd2);

      // reset landing on the commit edge of a pending write
      axi_write(32'h8000_0020, 3'd2, 32'h1234_5678, 4'hF, 0, 0);
      @(negedge clock);
      awaddr = 32'h8000_0020; awsize = 3'd2; awvalid = 1'b1;
      wdata = 32'hFFFF_FFFF; wstrb = 4'hF; wvalid = 1'b1;
      check("rstw_ready", {awready, wready}, 2'b11);
      @(negedge clock);
      awvalid = 1'b0; wvalid = 1'b0;
      repeat (WR_LAT) @(negedge clock);
      check("rstw_pre_bvalid", bvalid, 0);
      reset = 1'b1;
      @(negedge clock);
      check("rstw_bvalid", bvalid, 0);
      check("rstw_ready_forced", {arready, awready, wready}, 0);
      reset = 1'b0;
      @(negedge clock);
      check("rstw_ready_after", {awready, wready}, 2'b11);
      check("rstw_bvalid_after", bvalid, 0);
      axi_read(32'h8000_0020, 3'd2);
`endif

      repeat (2) @(negedge clock);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
